// File: rtl/dsp_mac_sequencer.sv
// Job sequencer that streams unsigned operand pairs into a DSP48A1 slice and
// steers OPMODE/clock enables so every product lands in P exactly once.
module dsp_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic             job_sub,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cep,
    input  logic [47:0]      dsp_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             sub_q;

    logic             issue;
    logic             issue_last;

    logic             v1;
    logic             v2;
    logic             v3;
    logic             first1;
    logic             last1;
    logic             last2;
    logic             last3;

    assign job_ready  = (state == ST_IDLE);
    assign s_ready    = (state == ST_RUN);
    assign res_valid  = (state == ST_RESULT);
    assign busy       = (state != ST_IDLE);

    assign issue      = s_valid & s_ready;
    assign issue_last = issue && (cnt == (len_q - LEN_W'(1)));

    // Operands reach the slice's A1/B1 registers in the accept cycle itself.
    assign dsp_a   = issue ? s_a : 18'd0;
    assign dsp_b   = issue ? s_b : 18'd0;
    assign dsp_cea = issue;
    assign dsp_ceb = issue;

    // The first product of a job selects Z=0 so no old P leaks into the new sum.
    assign dsp_cem      = v1;
    assign dsp_ceopmode = v1;
    assign dsp_cep      = v2;
    assign dsp_opmode   = v1 ? {sub_q, 3'b000, (first1 ? 2'b00 : 2'b10), 2'b01} : 8'h00;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            first1 <= 1'b0;
            last1  <= 1'b0;
            last2  <= 1'b0;
            last3  <= 1'b0;
        end else begin
            v1     <= issue;
            first1 <= issue && (cnt == '0);
            last1  <= issue_last;
            v2     <= v1;
            last2  <= last1;
            v3     <= v2;
            last3  <= last2;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            sub_q    <= 1'b0;
            cnt      <= '0;
            res_data <= 48'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        len_q <= job_len;
                        sub_q <= job_sub;
                        cnt   <= '0;
                        if (job_len == '0) begin
                            res_data <= 48'd0;
                            state    <= ST_RESULT;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        cnt <= cnt + LEN_W'(1);
                        if (issue_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (v3 && last3) begin
                        res_data <= dsp_p;
                        state    <= ST_RESULT;
                    end
                end
                default: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice model, result
// scoreboard and clock-enable pipeline monitor.
module tb_dsp_mac_sequencer;

    localparam int LEN_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [LEN_W-1:0] job_len = '0;
    logic             job_sub = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [17:0]      s_a = '0;
    logic [17:0]      s_b = '0;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_cea;
    logic             dsp_ceb;
    logic             dsp_cem;
    logic             dsp_ceopmode;
    logic             dsp_cep;
    logic [47:0]      dsp_p;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [47:0]      res_data;
    logic             busy;

    always #5 CLK = ~CLK;

    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_sub(job_sub),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
        .dsp_ceopmode(dsp_ceopmode), .dsp_cep(dsp_cep), .dsp_p(dsp_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    // Slice model: A1/B1, M, OPMODE and P registers; the slice has no reset here.
    logic [17:0] a1Reg = '0;
    logic [17:0] b1Reg = '0;
    logic [35:0] mReg = '0;
    logic [7:0]  opReg = '0;
    logic [47:0] pReg = '0;
    assign dsp_p = pReg;

    function automatic logic [47:0] slicePost(input logic [7:0] op, input logic [35:0] m,
                                              input logic [47:0] p);
        logic [47:0] x;
        logic [47:0] z;
        x = (op[1:0] == 2'b01) ? {12'h000, m} : 48'd0;
        z = (op[3:2] == 2'b10) ? p : 48'd0;
        return op[7] ? (z - x) : (z + x);
    endfunction

    always @(posedge CLK) begin
        if (dsp_cea) a1Reg <= dsp_a;
        if (dsp_ceb) b1Reg <= dsp_b;
        if (dsp_cem) mReg <= 36'(a1Reg) * 36'(b1Reg);
        if (dsp_ceopmode) opReg <= dsp_opmode;
        if (dsp_cep) pReg <= slicePost(opReg, mReg, pReg);
    end

    // Enables must trail each accepted pair by 0/1/2 cycles and stay low in bubbles.
    int   cyc = 0;
    int   ceaCount = 0;
    int   cemCount = 0;
    int   ceopCount = 0;
    int   cepCount = 0;
    int   pipeErrors = 0;
    logic issueNow = 1'b0;
    logic issueD1 = 1'b0;
    logic issueD2 = 1'b0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (!RST_N) begin
            issueD1 = 1'b0;
            issueD2 = 1'b0;
        end else begin
            issueNow = s_valid & s_ready;
            if (dsp_cea) ceaCount = ceaCount + 1;
            if (dsp_cem) cemCount = cemCount + 1;
            if (dsp_ceopmode) ceopCount = ceopCount + 1;
            if (dsp_cep) cepCount = cepCount + 1;
            if (dsp_cea !== issueNow || dsp_ceb !== issueNow || dsp_cem !== issueD1 ||
                dsp_ceopmode !== issueD1 || dsp_cep !== issueD2)
                pipeErrors = pipeErrors + 1;
            if (!issueD1 && dsp_opmode !== 8'h00) pipeErrors = pipeErrors + 1;
            issueD2 = issueD1;
            issueD1 = issueNow;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [47:0] expQ[$];
    logic [17:0] pairA[16];
    logic [17:0] pairB[16];
    int          lastAccept = 0;

    task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic startJob(input int len, input bit sub, input logic [47:0] expected);
        int w = 0;
        @(posedge CLK); #1;
        job_valid = 1'b1;
        job_len   = LEN_W'(len);
        job_sub   = sub;
        @(negedge CLK);
        while (!job_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        checkOutput("job_accept", 48'(job_ready), 48'd1);
        lastAccept = cyc;
        expQ.push_back(expected);
        @(posedge CLK); #1;
        job_valid = 1'b0;
    endtask

    task automatic feedPairs(input int first, input int count, input int maxGap);
        for (int i = first; i < first + count; i++) begin
            int gap = (maxGap > 0) ? int'($urandom_range(maxGap, 1)) : 0;
            int w = 0;
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge CLK); #1;
            end
            s_valid = 1'b1;
            s_a = pairA[i];
            s_b = pairB[i];
            @(negedge CLK);
            while (!s_ready && w < 50) begin
                @(negedge CLK);
                w++;
            end
            checkOutput("pair_accept", 48'(s_ready), 48'd1);
            lastAccept = cyc;
            @(posedge CLK); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic finishJob(input int hold, input int expLatency);
        int          w = 0;
        logic [47:0] held;
        logic [47:0] exp;
        @(negedge CLK);
        while (!res_valid && w < 100) begin
            @(negedge CLK);
            w++;
        end
        checkOutput("res_valid_seen", 48'(res_valid), 48'd1);
        checkOutput("res_latency", 48'(cyc - lastAccept), 48'(expLatency));
        held = res_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            job_valid = 1'b1;
            job_len   = LEN_W'(3);
            @(negedge CLK);
            checkOutput("hold_data", res_data, held);
            checkOutput("hold_job_ready", 48'(job_ready), 48'd0);
            checkOutput("hold_res_valid", 48'(res_valid), 48'd1);
        end
        @(posedge CLK); #1;
        job_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);
        checkOutput("sb_depth", 48'(expQ.size()), 48'd1);
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkOutput("res_data", res_data, exp);
        end
        @(posedge CLK); #1;
        res_ready = 1'b0;
        @(negedge CLK);
        checkOutput("job_ready_after", 48'(job_ready), 48'd1);
        checkOutput("busy_after", 48'(busy), 48'd0);
        @(posedge CLK); #1;
    endtask

    task automatic applyStimulus(input int len, input bit sub, input logic [47:0] expected,
                                 input int maxGap, input int hold);
        int a0 = ceaCount;
        int m0 = cemCount;
        int o0 = ceopCount;
        int p0 = cepCount;
        startJob(len, sub, expected);
        if (len > 0) feedPairs(0, len, maxGap);
        finishJob(hold, (len > 0) ? 4 : 1);
        checkOutput("cea_pulses", 48'(ceaCount - a0), 48'(len));
        checkOutput("cem_pulses", 48'(cemCount - m0), 48'(len));
        checkOutput("ceopmode_pulses", 48'(ceopCount - o0), 48'(len));
        checkOutput("cep_pulses", 48'(cepCount - p0), 48'(len));
        checkOutput("ce_pipeline_errors", 48'(pipeErrors), 48'd0);
    endtask

    function automatic logic [47:0] modelSum(input int len, input bit sub);
        logic [47:0] acc = 48'd0;
        for (int i = 0; i < len; i++) acc = acc + 48'(36'(pairA[i]) * 36'(pairB[i]));
        return sub ? (48'd0 - acc) : acc;
    endfunction

    task automatic loadBasic();
        for (int i = 0; i < 4; i++) begin
            pairA[i] = 18'(i + 1);
            pairB[i] = 18'(i + 5);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge CLK);
        checkOutput("rst_busy", 48'(busy), 48'd0);
        checkOutput("rst_s_ready", 48'(s_ready), 48'd0);
        checkOutput("rst_res_valid", 48'(res_valid), 48'd0);
        checkOutput("rst_res_data", res_data, 48'd0);
        checkOutput("rst_dsp_bus", {dsp_a, dsp_b, dsp_opmode, 4'd0}, 48'd0);
        checkOutput("rst_ces", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep}), 48'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checkOutput("job_ready_after_reset", 48'(job_ready), 48'd1);

        $display("[TB] basic accumulate");
        loadBasic();
        applyStimulus(4, 1'b0, 48'd70, 0, 0);

        $display("[TB] gapped stream");
        applyStimulus(4, 1'b0, 48'd70, 3, 0);

        $display("[TB] subtract");
        pairA[0] = 18'd10; pairB[0] = 18'd10;
        pairA[1] = 18'd3;  pairB[1] = 18'd2;
        applyStimulus(2, 1'b1, 48'hFFFF_FFFF_FF96, 1, 0);

        $display("[TB] operand width extremes");
        pairA[0] = 18'h3FFFF; pairB[0] = 18'h3FFFF;
        pairA[1] = 18'h3FFFF; pairB[1] = 18'h3FFFF;
        applyStimulus(2, 1'b0, 48'h001F_FFF0_0002, 0, 0);

        $display("[TB] zero-length job");
        applyStimulus(0, 1'b0, 48'd0, 0, 0);

        $display("[TB] result back-pressure then independent job");
        pairA[0] = 18'd100; pairB[0] = 18'd200;
        pairA[1] = 18'd7;   pairB[1] = 18'd3;
        applyStimulus(2, 1'b0, 48'd20021, 2, 5);
        pairA[0] = 18'd7; pairB[0] = 18'd9;
        applyStimulus(1, 1'b0, 48'd63, 0, 0);

        $display("[TB] random jobs");
        for (int j = 0; j < 3; j++) begin
            int  len = int'($urandom_range(9, 3));
            bit  sub = 1'(j);
            for (int i = 0; i < len; i++) begin
                pairA[i] = 18'($urandom);
                pairB[i] = 18'($urandom);
            end
            applyStimulus(len, sub, modelSum(len, sub), 2, j);
        end

        $display("[TB] reset in the middle of a job");
        loadBasic();
        startJob(4, 1'b0, 48'd70);
        feedPairs(0, 2, 0);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_busy", 48'(busy), 48'd0);
        checkOutput("midrst_s_ready", 48'(s_ready), 48'd0);
        checkOutput("midrst_res_valid", 48'(res_valid), 48'd0);
        checkOutput("midrst_res_data", res_data, 48'd0);
        checkOutput("midrst_dsp_bus", {dsp_a, dsp_b, dsp_opmode, 4'd0}, 48'd0);
        checkOutput("midrst_ces", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep}), 48'd0);
        expQ.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        checkOutput("midrst_job_ready", 48'(job_ready), 48'd1);
        pairA[0] = 18'd3; pairB[0] = 18'd4;
        applyStimulus(1, 1'b0, 48'd12, 0, 0);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
